count_bcd_display: RTL and testbench

Downstream consumer of the 8-bit ripple-counter value. It samples the counter output through a synchroniser with a stability filter, converts the stable binary value to 3-digit BCD with an iterative shift-add-3 FSM, and drives a 4-digit multiplexed common-anode seven-segment display. Leading zeros are blanked.

---
 rtl/count_disp_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 95 +++++++++
 rtl/count_bcd_display.sv | 142 ++++++++++++++
 tb/tb_count_bcd_display.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// count_disp_pkg
// Shared definitions for the counter display slice: the BCD conversion FSM
// state type, the seven-segment glyph table, the blank/off patterns and the
// number of shift-add-3 iterations needed for an 8-bit input.
package count_disp_pkg;

  // Conversion FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // One shift per input bit.
  localparam int CONV_ITERS = 8;

  // Active-low segment patterns {g,f,e,d,c,b,a} for decimal digits.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Maps a BCD nibble to its glyph; an out-of-range nibble shows nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    if (digit > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_DIGIT[digit];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Iterative 8-bit binary to 3-digit BCD converter (shift-add-3 / double dabble).
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   start  - request a conversion of bin; accepted only while idle
//   bin    - binary value to convert
//   busy   - high while a conversion is in progress (SHIFT or DONE)
//   done   - one-cycle pulse in the cycle bcd has just been updated
//   bcd    - latched result {hundreds, tens, ones}
module bin2bcd_seq
  import count_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state;
  conv_state_t next_state;
  logic [19:0] shreg;
  logic [19:0] shreg_next;
  logic [3:0]  iter;

  // State register. Reset always returns to IDLE, which is what aborts a
  // conversion in flight without ever reaching DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE waits for start, SHIFT runs for exactly one
  // iteration per input bit, DONE lasts one cycle to publish the result.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (iter == 4'(CONV_ITERS - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One double-dabble step: correct every BCD nibble that would overflow
  // past 9 once doubled, then shift the whole register left by one.
  always_comb begin
    shreg_next = shreg;
    for (int i = 0; i < 3; i++) begin
      if (shreg_next[8 + 4*i +: 4] >= 4'd5) begin
        shreg_next[8 + 4*i +: 4] = shreg_next[8 + 4*i +: 4] + 4'd3;
      end
    end
    shreg_next = {shreg_next[18:0], 1'b0};
  end

  // Datapath: load on start, step while shifting, latch the result and
  // raise done for a single cycle when leaving DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      iter  <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= {12'b0, bin};
            iter  <= '0;
          end
        end
        SHIFT: begin
          shreg <= shreg_next;
          iter  <= iter + 4'd1;
        end
        DONE: begin
          bcd  <= shreg[19:8];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display
// Samples a glitchy ripple-counter value, converts the stable value to BCD
// and scans it onto a 4-digit common-anode seven-segment display with
// leading-zero blanking.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   count_in - counter value, may glitch while the ripple settles
//   an       - digit anodes, active low, an[0] = ones digit
//   seg      - segments {g,f,e,d,c,b,a}, active low
//   dp       - decimal point, active low, always off
//   bcd      - latched conversion result {hundreds, tens, ones}
//   busy     - high while a conversion is running
//   upd      - one-cycle pulse when bcd is updated
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 16
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        upd
);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] sample;
  logic [7:0] last;
  logic       start;

  logic [REFRESH_BITS-1:0] prescaler;
  logic [1:0]              scan_idx;

  logic [3:0] nib;
  logic       shown;
  logic [6:0] glyph;
  logic [3:0] digit_an;
  logic [6:0] digit_seg;

  // Two-stage synchroniser plus a stability filter: sample only follows
  // when both stages agree, so a value has to survive two edges and a
  // single-cycle ripple glitch is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      sample <= '0;
    end else begin
      sync1 <= count_in;
      sync2 <= sync1;
      if (sync1 == sync2) begin
        sample <= sync2;
      end
    end
  end

  // Change detect. last only moves when the converter actually accepts a
  // new value, so a change seen while busy is picked up on the next idle
  // cycle and the final bcd always matches the last stable input.
  assign start = (sample != last);

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= '0;
    end else if (start && !busy) begin
      last <= sample;
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (sample),
    .busy  (busy),
    .done  (upd),
    .bcd   (bcd)
  );

  // Free-running refresh prescaler; the scan slot steps whenever it wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (&prescaler) begin
        scan_idx <= scan_idx + 2'd1;
      end
    end
  end

  // Slot decode with leading-zero blanking. Slot 3 is never lit; a slot
  // holding an impossible nibble is blanked like a leading zero.
  always_comb begin
    nib       = 4'd0;
    shown     = 1'b0;
    digit_an  = AN_OFF;
    digit_seg = SEG_BLANK;
    case (scan_idx)
      2'd0: begin
        nib   = bcd[3:0];
        shown = 1'b1;
      end
      2'd1: begin
        nib   = bcd[7:4];
        shown = (bcd[11:8] != 4'd0) || (bcd[7:4] != 4'd0);
      end
      2'd2: begin
        nib   = bcd[11:8];
        shown = (bcd[11:8] != 4'd0);
      end
      default: ;
    endcase
    glyph = seg_decode(nib);
    if (shown && (glyph != SEG_BLANK)) begin
      digit_seg = glyph;
      digit_an  = ~(4'b0001 << scan_idx);
    end
  end

  // Register the display drive so the pins are glitch-free; this is why
  // an/seg trail scan_idx by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= digit_an;
      seg <= digit_seg;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display
// Self-checking bench for count_bcd_display with a fast refresh prescaler.
// Expected BCD and display contents come from decimal arithmetic on the
// applied value and a local glyph table.
module tb_count_bcd_display;

  logic        clk;
  logic        reset;
  logic [7:0]  count_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [11:0] bcd;
  logic        busy;
  logic        upd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] upd_q[$];
  logic [7:0]  cur_val = 8'd0;

  localparam logic [6:0] GLYPH [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  count_bcd_display #(.REFRESH_BITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .bcd      (bcd),
    .busy     (busy),
    .upd      (upd)
  );

  // 100 MHz style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard of every published result, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (upd) upd_q.push_back(bcd);
  end

  // Decimal reference: the BCD word a correct converter must produce.
  function automatic logic [11:0] model_bcd(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  // Watch 32 consecutive cycles (two full scan periods) and check how many
  // cycles each anode is lit and that every lit cycle carries the right glyph.
  task automatic check_scan(input string name, input int v);
    int h, t, o;
    int c0, c1, c2, cb, bad_seg, bad_an;
    int e1, e2;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    c0 = 0; c1 = 0; c2 = 0; cb = 0; bad_seg = 0; bad_an = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin c0++; if (seg !== GLYPH[o]) bad_seg++; end
        4'b1101: begin c1++; if (seg !== GLYPH[t]) bad_seg++; end
        4'b1011: begin c2++; if (seg !== GLYPH[h]) bad_seg++; end
        4'b1111: begin cb++; if (seg !== 7'h7F) bad_seg++; end
        default: bad_an++;
      endcase
    end
    e1 = (h != 0 || t != 0) ? 8 : 0;
    e2 = (h != 0) ? 8 : 0;
    n_checks++;
    if (c0 !== 8) begin
      n_fail++;
      $display("[TB] FAIL %s scan_ones_count: got %0d want 8", name, c0);
    end
    n_checks++;
    if (c1 !== e1) begin
      n_fail++;
      $display("[TB] FAIL %s scan_tens_count: got %0d want %0d", name, c1, e1);
    end
    n_checks++;
    if (c2 !== e2) begin
      n_fail++;
      $display("[TB] FAIL %s scan_hund_count: got %0d want %0d", name, c2, e2);
    end
    n_checks++;
    if (cb !== 32 - 8 - e1 - e2) begin
      n_fail++;
      $display("[TB] FAIL %s scan_blank_count: got %0d want %0d", name, cb, 32 - 8 - e1 - e2);
    end
    n_checks++;
    if (bad_seg !== 0 || bad_an !== 0) begin
      n_fail++;
      $display("[TB] FAIL %s scan_glyphs: bad_seg=%0d bad_an=%0d want 0/0", name, bad_seg, bad_an);
    end
    n_checks++;
    if (dp !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s dp: got %b want 1", name, dp);
    end
  endtask

  // Apply a value just before edge N and check the single upd pulse lands
  // after edge N+12 with the right BCD word.
  task automatic apply_and_time(input string name, input logic [7:0] v);
    int pulses, first_k;
    logic [11:0] got;
    pulses = 0; first_k = -1; got = 12'h000;
    @(negedge clk);
    count_in = v;
    cur_val  = v;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (upd) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          got = bcd;
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("[TB] FAIL %s upd_count: got %0d want 1", name, pulses);
    end
    n_checks++;
    if (first_k !== 12) begin
      n_fail++;
      $display("[TB] FAIL %s upd_latency: got edge N+%0d want N+12", name, first_k);
    end
    n_checks++;
    if (got !== model_bcd(v)) begin
      n_fail++;
      $display("[TB] FAIL %s bcd_at_upd: got %h want %h", name, got, model_bcd(v));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    count_in = 8'd0;
    cur_val = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_display: an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    end
    n_checks++;
    if (bcd !== 12'h000 || busy !== 1'b0 || upd !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: bcd=%h busy=%b upd=%b want 000/0/0", bcd, busy, upd);
    end
    @(negedge clk);
    reset = 1'b0;
    upd_q.delete();
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (upd_q.size() !== 0 || bcd !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_no_conv: pulses=%0d bcd=%h want 0/000", upd_q.size(), bcd);
    end
    check_scan("reset", 0);
  endtask

  task automatic test_max_value();
    apply_and_time("max255", 8'd255);
    check_scan("max255", 255);
  endtask

  task automatic test_single_digit();
    apply_and_time("seven", 8'd7);
    check_scan("seven", 7);
  endtask

  task automatic test_back_to_back();
    upd_q.delete();
    @(negedge clk);
    count_in = 8'd100;
    // Edges N..N+7 pass; 101 lands just before N+8, five cycles after load.
    repeat (8) @(posedge clk);
    @(negedge clk);
    count_in = 8'd101;
    cur_val = 8'd101;
    repeat (40) @(posedge clk);
    #2;
    n_checks++;
    if (upd_q.size() !== 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d pulses want 2", upd_q.size());
    end else begin
      n_checks++;
      if (upd_q[0] !== 12'h100 || upd_q[1] !== 12'h101) begin
        n_fail++;
        $display("[TB] FAIL b2b_values: got %h,%h want 100,101", upd_q[0], upd_q[1]);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_seen;
    busy_seen = 0;
    upd_q.delete();
    @(negedge clk);
    count_in = 8'hFF;
    @(negedge clk);
    count_in = cur_val;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_checks++;
    if (busy_seen !== 0 || upd_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_filter: busy_cycles=%0d pulses=%0d want 0/0", busy_seen, upd_q.size());
    end
    n_checks++;
    if (bcd !== model_bcd(cur_val)) begin
      n_fail++;
      $display("[TB] FAIL glitch_bcd: got %h want %h", bcd, model_bcd(cur_val));
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int r = 0; r < 6; r++) begin
      v = 8'((int'(cur_val) + 1 + int'($urandom_range(254))) % 256);
      apply_and_time($sformatf("rand%0d_%0d", r, v), v);
      check_scan($sformatf("rand%0d_%0d", r, v), int'(v));
    end
  endtask

  task automatic test_reset_mid_conv();
    upd_q.delete();
    @(negedge clk);
    count_in = (cur_val == 8'd200) ? 8'd201 : 8'd200;
    // Load at N+3, three shifts by N+6; reset hits on edge N+7.
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midconv_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    count_in = 8'd42;
    cur_val = 8'd42;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || bcd !== 12'h000 || upd !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midconv_reset_state: busy=%b bcd=%h upd=%b want 0/000/0", busy, bcd, upd);
    end
    n_checks++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      n_fail++;
      $display("[TB] FAIL midconv_reset_display: an=%b seg=%b want 1111/1111111", an, seg);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    n_checks++;
    if (upd_q.size() !== 1) begin
      n_fail++;
      $display("[TB] FAIL midconv_pulses: got %0d want 1", upd_q.size());
    end else begin
      n_checks++;
      if (upd_q[0] !== 12'h042) begin
        n_fail++;
        $display("[TB] FAIL midconv_value: got %h want 042", upd_q[0]);
      end
    end
    n_checks++;
    if (bcd !== 12'h042) begin
      n_fail++;
      $display("[TB] FAIL midconv_bcd: got %h want 042", bcd);
    end
    check_scan("after_reset42", 42);
  endtask

  initial begin
    $display("[TB] starting count_bcd_display bench");
    test_reset();
    test_max_value();
    test_single_digit();
    test_back_to_back();
    test_glitch();
    test_random();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
